// File: rtl/arbitro_prioridade.sv
// Two-entity arbiter for a shared function resource: profile priority, round-robin
// tie-break, bounded hold slot when the other entity waits, and preemption.
module arbitro_prioridade #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [5:0] perfil0,
    input  logic       req1,
    input  logic [5:0] perfil1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [5:0] perfil_ativo,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    // Priority 1..6 from the one-hot bit position; anything not one-hot is 0.
    function automatic logic [2:0] prio_f(input logic [5:0] p);
        logic [2:0] r;
        r = 3'd0;
        if ((p != 6'd0) && ((p & (p - 6'd1)) == 6'd0)) begin
            for (int i = 0; i < 6; i++) begin
                if (p[i]) r = 3'(i + 1);
                else      r = r;
            end
        end else begin
            r = 3'd0;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [5:0]       pa_q, pa_d;
    logic             red_q;

    logic [2:0] prio0_s, prio1_s, prioa_s;
    logic       valid0_s, valid1_s, cnt_max_s;
    logic       pick0_s, pick1_s, rel0_s, rel1_s;

    assign prio0_s   = prio_f(perfil0);
    assign prio1_s   = prio_f(perfil1);
    assign prioa_s   = prio_f(pa_q);
    assign valid0_s  = req0 && (prio0_s != 3'd0);
    assign valid1_s  = req1 && (prio1_s != 3'd0);
    assign cnt_max_s = (cnt_q == CNT_MAX);

    // Equal priority goes to whichever entity was not served last.
    assign pick0_s = valid0_s && (!valid1_s || (prio0_s > prio1_s) ||
                                  ((prio0_s == prio1_s) && last_q));
    assign pick1_s = valid1_s && (!valid0_s || (prio1_s > prio0_s) ||
                                  ((prio0_s == prio1_s) && !last_q));

    assign rel0_s = !valid0_s || (perfil0 != pa_q) ||
                    (valid1_s && (prio1_s > prioa_s)) || (cnt_max_s && valid1_s);
    assign rel1_s = !valid1_s || (perfil1 != pa_q) ||
                    (valid0_s && (prio0_s > prioa_s)) || (cnt_max_s && valid0_s);

    // Next-state, hold counter, round-robin pointer and active profile.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pa_d    = pa_q;
        case (state_q)
            ST_IDLE: begin
                pa_d  = 6'd0;
                cnt_d = '0;
                if (pick0_s) begin
                    state_d = ST_SERVE0;
                    pa_d    = perfil0;
                    last_d  = 1'b0;
                end else if (pick1_s) begin
                    state_d = ST_SERVE1;
                    pa_d    = perfil1;
                    last_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE0: begin
                if (rel0_s) begin
                    state_d = ST_GAP;
                    pa_d    = 6'd0;
                end else begin
                    cnt_d = cnt_max_s ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ST_SERVE1: begin
                if (rel1_s) begin
                    state_d = ST_GAP;
                    pa_d    = 6'd0;
                end else begin
                    cnt_d = cnt_max_s ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                pa_d    = 6'd0;
            end
            default: begin
                state_d = ST_IDLE;
                pa_d    = 6'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; IE01 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            pa_q    <= 6'd0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pa_q    <= pa_d;
            red_q   <= valid0_s && valid1_s && (prio0_s == prio1_s);
        end
    end

    assign gnt0         = (state_q == ST_SERVE0);
    assign gnt1         = (state_q == ST_SERVE1);
    assign perfil_ativo = pa_q;
    assign led_red      = red_q;
    assign led_green    = gnt0;
    assign led_blue     = gnt1;

endmodule

// File: tb/tb_arbitro_prioridade.sv
// Table-driven bench for arbitro_prioridade with HOLD_CYCLES = 8; expected outputs
// are queued when each vector is driven and popped after the following clock edge.
module tb_arbitro_prioridade;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [5:0] perfil0, perfil1;
    logic       gnt0, gnt1, led_red, led_green, led_blue;
    logic [5:0] perfil_ativo;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic       r0;
        logic [5:0] p0;
        logic       r1;
        logic [5:0] p1;
        logic [9:0] exp;
        string      nm;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] sb[$];

    arbitro_prioridade #(.HOLD_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .perfil0(perfil0), .req1(req1), .perfil1(perfil1),
        .gnt0(gnt0), .gnt1(gnt1), .perfil_ativo(perfil_ativo),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Expected output word {gnt0, gnt1, perfil_ativo, led_red, led_green, led_blue}.
    function automatic logic [9:0] mk(input logic g0, input logic g1,
                                      input logic [5:0] pa, input logic red);
        return {g0, g1, pa, red, g0, g1};
    endfunction

    task automatic add(input logic r0, input logic [5:0] p0, input logic r1,
                       input logic [5:0] p1, input logic g0, input logic g1,
                       input logic [5:0] pa, input logic red, input string nm);
        vec_t v;
        v.r0 = r0; v.p0 = p0; v.r1 = r1; v.p1 = p1;
        v.exp = mk(g0, g1, pa, red);
        v.nm  = nm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx);
        logic [9:0] got, exp;
        got = {gnt0, gnt1, perfil_ativo, led_red, led_green, led_blue};
        n_tot++;
        if (sb.size() == 0) begin
            $display("FAIL %s[%0d]: scoreboard empty, got %b", nm, idx, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp)
                $display("FAIL %s[%0d]: got {g0,g1,pa,r,g,b}=%b required %b", nm, idx, got, exp);
            else
                n_pass++;
        end
    endtask

    initial begin
        logic [5:0] t;
        logic [5:0] z;
        t = 6'b001000;
        z = 6'b000000;

        // After reset release: tie at prio 3, IE01 first, then release.
        add(1'b1, 6'b000100, 1'b1, 6'b000100, 1'b1, 1'b0, 6'b000100, 1'b1, "rst_tie");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "rst_gap");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "rst_idle");
        // Higher profile wins.
        add(1'b1, 6'b000010, 1'b1, 6'b010000, 1'b0, 1'b1, 6'b010000, 1'b0, "prio");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "prio_gap");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "prio_idle");
        // Non-one-hot profile is never granted.
        add(1'b1, 6'b000110, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "inval");
        add(1'b1, 6'b000110, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "inval");
        add(1'b1, 6'b000110, 1'b1, 6'b000001, 1'b0, 1'b1, 6'b000001, 1'b0, "inval_vs");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "inval_gap");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "inval_idle");
        // Profile change by owner counts as release, then regrant.
        add(1'b1, 6'b000001, 1'b0, z, 1'b1, 1'b0, 6'b000001, 1'b0, "pchg");
        add(1'b1, 6'b000001, 1'b0, z, 1'b1, 1'b0, 6'b000001, 1'b0, "pchg");
        add(1'b1, 6'b000010, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pchg_gap");
        add(1'b1, 6'b000010, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pchg_idle");
        add(1'b1, 6'b000010, 1'b0, z, 1'b1, 1'b0, 6'b000010, 1'b0, "pchg_regnt");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pchg_rel");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pchg_rel");
        // Preemption by prio 6 against owner at prio 2.
        add(1'b1, 6'b000010, 1'b0, z, 1'b1, 1'b0, 6'b000010, 1'b0, "pre_own");
        add(1'b1, 6'b000010, 1'b1, 6'b100000, 1'b0, 1'b0, z, 1'b0, "pre_gap");
        add(1'b1, 6'b000010, 1'b1, 6'b100000, 1'b0, 1'b0, z, 1'b0, "pre_idle");
        add(1'b1, 6'b000010, 1'b1, 6'b100000, 1'b0, 1'b1, 6'b100000, 1'b0, "pre_gnt1");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pre_rel");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "pre_rel");
        // No competitor: hold indefinitely; a late lower-prio competitor ends it at once.
        for (int i = 0; i < 12; i++)
            add(1'b1, 6'b000100, 1'b0, z, 1'b1, 1'b0, 6'b000100, 1'b0, "solo_hold");
        add(1'b1, 6'b000100, 1'b1, 6'b000001, 1'b0, 1'b0, z, 1'b0, "sat_gap");
        add(1'b1, 6'b000100, 1'b1, 6'b000001, 1'b0, 1'b0, z, 1'b0, "sat_idle");
        add(1'b1, 6'b000100, 1'b1, 6'b000001, 1'b1, 1'b0, 6'b000100, 1'b0, "sat_regnt");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "sat_rel");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "sat_rel");
        // Tie round-robin with 8-cycle slots; IE01 was served last.
        for (int i = 0; i < 8; i++) add(1'b1, t, 1'b1, t, 1'b0, 1'b1, t, 1'b1, "rr_gnt1");
        for (int i = 0; i < 2; i++) add(1'b1, t, 1'b1, t, 1'b0, 1'b0, z, 1'b1, "rr_gap1");
        for (int i = 0; i < 8; i++) add(1'b1, t, 1'b1, t, 1'b1, 1'b0, t, 1'b1, "rr_gnt0");
        for (int i = 0; i < 2; i++) add(1'b1, t, 1'b1, t, 1'b0, 1'b0, z, 1'b1, "rr_gap0");
        add(1'b1, t, 1'b1, t, 1'b0, 1'b1, t, 1'b1, "rr_gnt1b");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "rr_rel");
        add(1'b0, z, 1'b0, z, 1'b0, 1'b0, z, 1'b0, "rr_rel");

        // Reset held with both requesting.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        perfil0 = 6'b000100; perfil1 = 6'b000100;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(10'd0);
        chk("reset_hold", 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req0 = vecs[i].r0; perfil0 = vecs[i].p0;
            req1 = vecs[i].r1; perfil1 = vecs[i].p1;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            chk(vecs[i].nm, i);
            @(negedge clk);
        end

        // Reset asserted while IE02 owns the resource.
        req0 = 1'b0; perfil0 = z; req1 = 1'b1; perfil1 = 6'b010000;
        sb.push_back(mk(1'b0, 1'b1, 6'b010000, 1'b0));
        @(posedge clk);
        #1;
        chk("mid_gnt1", 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back(10'd0);
        chk("mid_reset_async", 0);
        @(negedge clk);
        req1 = 1'b0; perfil1 = z;
        rst_n = 1'b1;
        sb.push_back(10'd0);
        @(posedge clk);
        #1;
        chk("post_reset_idle", 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
